// File: rtl/eeprom_arb_pkg.sv
// Shared definitions for the EEPROM access arbiter: FSM encoding, port indices
// and the microsecond-to-cycle conversion used to size the timers.
package eeprom_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_RECOVER   = 2'd3
   } arb_state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Rounds down, but never below one cycle so a counter always exists.
   function automatic int unsigned us_to_cycles(input longint unsigned us,
                                                input longint unsigned freq_hz);
      longint unsigned c;
      c = (us * freq_hz) / 64'd1000000;
      if (c == 64'd0) c = 64'd1;
      return c[31:0];
   endfunction

   localparam int unsigned DEF_RECOVER_CYC = us_to_cycles(64'd5000, 64'd50000000);
   localparam int unsigned DEF_TIMEOUT_CYC = us_to_cycles(64'd2000, 64'd50000000);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: the port that did not win last time is preferred.
module rr_arbiter2
   import eeprom_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic       grant_vld_o,
   output logic       grant_idx_o
);

   logic last_grant_q;
   logic last_grant_d;
   logic pref;

   always_comb begin
      pref         = ~last_grant_q;
      grant_vld_o  = |req_i;
      grant_idx_o  = req_i[pref] ? pref : ~pref;
      last_grant_d = last_grant_q;
      if (en_i && grant_vld_o) last_grant_d = grant_idx_o;
   end

   // Reset to port 1 so port 0 gets the first grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) last_grant_q <= PORT1;
      else       last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Shares one single-byte I2C EEPROM engine between two requesters, one
// transaction at a time, with a done watchdog and post-write recovery delay.
module eeprom_access_arbiter
   import eeprom_arb_pkg::*;
#(
   parameter int unsigned SYS_CLK_FREQ  = 50000000,
   parameter int unsigned WR_RECOVER_US = 5000,
   parameter int unsigned TIMEOUT_US    = 2000,
   parameter logic [6:0]  EQUI_ADDR     = 7'b1010_000
) (
   input  logic       sclk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] req_we,
   input  logic [7:0] req_addr0,
   input  logic [7:0] req_addr1,
   input  logic [7:0] req_wdata0,
   input  logic [7:0] req_wdata1,
   output logic [1:0] ack,
   output logic       ack_err,
   output logic [7:0] rdata,
   output logic       busy,
   output logic [6:0] equi_addr,
   output logic [7:0] reg_addr,
   output logic [7:0] write_byte,
   output logic       write_trigger,
   output logic       read_trigger,
   input  logic       write_done,
   input  logic       read_done,
   input  logic [7:0] read_byte
);

   localparam int unsigned RECOVER_CYC = us_to_cycles(64'(WR_RECOVER_US), 64'(SYS_CLK_FREQ));
   localparam int unsigned TIMEOUT_CYC = us_to_cycles(64'(TIMEOUT_US), 64'(SYS_CLK_FREQ));
   localparam int unsigned MAX_CYC     = (RECOVER_CYC > TIMEOUT_CYC) ? RECOVER_CYC : TIMEOUT_CYC;
   localparam int          CNT_W       = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   arb_state_e       state_q;
   logic             gnt_q;
   logic             we_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       ack_q;
   logic             ack_err_q;
   logic [7:0]       rdata_q;
   logic [7:0]       reg_addr_q;
   logic [7:0]       write_byte_q;
   logic             wr_trig_q;
   logic             rd_trig_q;

   logic             grant_en;
   logic             gnt_vld;
   logic             gnt_idx;
   logic             done_match;

   // The cycle that carries an ack is skipped so the acked port's still-high
   // req is not mistaken for a fresh request before it can drop.
   assign grant_en   = (state_q == ST_IDLE) && (ack_q == 2'b00);
   assign done_match = we_q ? write_done : read_done;

   rr_arbiter2 u_rr (
      .clk_i       (sclk),
      .rst_i       (rst),
      .req_i       (req),
      .en_i        (grant_en),
      .grant_vld_o (gnt_vld),
      .grant_idx_o (gnt_idx)
   );

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         gnt_q        <= PORT0;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         ack_q        <= 2'b00;
         ack_err_q    <= 1'b0;
         rdata_q      <= 8'h00;
         reg_addr_q   <= 8'h00;
         write_byte_q <= 8'h00;
         wr_trig_q    <= 1'b0;
         rd_trig_q    <= 1'b0;
      end else begin
         ack_q     <= 2'b00;
         ack_err_q <= 1'b0;
         wr_trig_q <= 1'b0;
         rd_trig_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_en && gnt_vld) begin
                  gnt_q        <= gnt_idx;
                  we_q         <= req_we[gnt_idx];
                  reg_addr_q   <= gnt_idx ? req_addr1 : req_addr0;
                  write_byte_q <= gnt_idx ? req_wdata1 : req_wdata0;
                  wr_trig_q    <= req_we[gnt_idx];
                  rd_trig_q    <= ~req_we[gnt_idx];
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_q   <= '0;
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (done_match) begin
                  ack_q[gnt_q] <= 1'b1;
                  if (we_q) begin
                     cnt_q   <= RECOVER_LOAD;
                     state_q <= ST_RECOVER;
                  end else begin
                     rdata_q <= read_byte;
                     state_q <= ST_IDLE;
                  end
               end else if (cnt_q == TIMEOUT_LAST) begin
                  // Engine state is unknown after a timeout, so back off as if a write happened.
                  ack_q[gnt_q] <= 1'b1;
                  ack_err_q    <= 1'b1;
                  cnt_q        <= RECOVER_LOAD;
                  state_q      <= ST_RECOVER;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_RECOVER: begin
               if (cnt_q == '0) state_q <= ST_IDLE;
               else             cnt_q   <= cnt_q - CNT_ONE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ack           = ack_q;
   assign ack_err       = ack_err_q;
   assign rdata         = rdata_q;
   assign busy          = (state_q != ST_IDLE);
   assign equi_addr     = EQUI_ADDR;
   assign reg_addr      = reg_addr_q;
   assign write_byte    = write_byte_q;
   assign write_trigger = wr_trig_q;
   assign read_trigger  = rd_trig_q;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Bench for eeprom_access_arbiter: transaction-window model plus directed
// scenarios with a stubbed I2C engine, clock scaled so timers stay short.
module tb_eeprom_access_arbiter;

   localparam int R = 500;  // 5000 us at 100 kHz
   localparam int T = 200;  // 2000 us at 100 kHz

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [1:0] req_we;
   logic [7:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
   logic [1:0] ack;
   logic       ack_err;
   logic [7:0] rdata;
   logic       busy;
   logic [6:0] equi_addr;
   logic [7:0] reg_addr, write_byte;
   logic       write_trigger, read_trigger;
   logic       write_done, read_done;
   logic [7:0] read_byte;

   eeprom_access_arbiter #(
      .SYS_CLK_FREQ  (100000),
      .WR_RECOVER_US (5000),
      .TIMEOUT_US    (2000),
      .EQUI_ADDR     (7'h50)
   ) dut (
      .sclk          (clk),
      .rst           (rst),
      .req           (req),
      .req_we        (req_we),
      .req_addr0     (req_addr0),
      .req_addr1     (req_addr1),
      .req_wdata0    (req_wdata0),
      .req_wdata1    (req_wdata1),
      .ack           (ack),
      .ack_err       (ack_err),
      .rdata         (rdata),
      .busy          (busy),
      .equi_addr     (equi_addr),
      .reg_addr      (reg_addr),
      .write_byte    (write_byte),
      .write_trigger (write_trigger),
      .read_trigger  (read_trigger),
      .write_done    (write_done),
      .read_done     (read_done),
      .read_byte     (read_byte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Model: tracks each transaction as a set of cycle windows.
   longint now = 0;
   bit     mvalid = 0;
   bit     m_inwait = 0;
   logic   m_port = 1'b0, m_we = 1'b0, m_last = 1'b1, mp;
   longint m_free_at = 0, m_wstart = 0, m_wend = 0, m_busy_end = 0;
   logic [1:0] e_ack = '0;
   logic       e_err = 0, e_busy = 0, e_wt = 0, e_rt = 0;
   logic [7:0] e_rdata = '0, e_addr = '0, e_wbyte = '0;

   always @(posedge clk) begin
      e_ack = 2'b00; e_err = 1'b0; e_wt = 1'b0; e_rt = 1'b0;
      if (rst) begin
         mvalid = 1; m_inwait = 0; m_last = 1'b1; m_busy_end = 0; m_free_at = now + 1;
         e_rdata = 8'h00; e_addr = 8'h00; e_wbyte = 8'h00;
      end else if (m_inwait) begin
         if (now >= m_wstart && (m_we ? write_done : read_done)) begin
            e_ack[m_port] = 1'b1;
            m_inwait = 0;
            if (m_we) begin
               m_busy_end = now + 1 + R;
               m_free_at  = m_busy_end;
            end else begin
               e_rdata    = read_byte;
               m_busy_end = now + 1;
               m_free_at  = now + 2;
            end
         end else if (now == m_wend) begin
            e_ack[m_port] = 1'b1;
            e_err = 1'b1;
            m_inwait = 0;
            m_busy_end = now + 1 + R;
            m_free_at  = m_busy_end;
         end
      end else if (now >= m_free_at && req != 2'b00) begin
         mp = req[~m_last] ? ~m_last : m_last;
         m_port = mp; m_last = mp;
         m_we = req_we[mp];
         e_addr  = mp ? req_addr1 : req_addr0;
         e_wbyte = mp ? req_wdata1 : req_wdata0;
         e_wt = m_we; e_rt = ~m_we;
         m_inwait = 1;
         m_wstart = now + 2;
         m_wend   = now + 1 + T;
         m_busy_end = 64'h7fff_ffff_ffff;
      end
      e_busy = (now + 1) < m_busy_end;
      now++;
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ntrig = 0, nack = 0;
   int trig_cyc = 0, ack_cyc = 0, done_cyc = 0;
   logic [7:0] trig_addr, trig_wbyte, ack_rdata;
   logic       trig_we, ack_err_s;
   logic [1:0] ack_port;
   logic [7:0] trig_log[$];
   logic [1:0] ack_log[$];
   logic [1:0] hold;
   bit         mute;
   bit         late_wdone;
   int         cd = 0;
   logic       cd_we;
   logic [7:0] cd_addr;
   logic [7:0] mem [256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      logic [36:0] act_v, exp_v;
      @(negedge clk);
      cyc++;
      if (mvalid) begin
         act_v = {ack, ack_err, rdata, busy, reg_addr, write_byte, write_trigger, read_trigger, equi_addr};
         exp_v = {e_ack, e_err, e_rdata, e_busy, e_addr, e_wbyte, e_wt, e_rt, 7'h50};
         checks++;
         if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_%0d outputs{ack,err,rdata,busy,addr,wbyte,wt,rt,equi}: got %h want %h",
                     cyc, act_v, exp_v);
         end
      end
      if (write_trigger || read_trigger) begin
         trig_cyc = cyc; trig_addr = reg_addr; trig_wbyte = write_byte; trig_we = write_trigger;
         trig_log.push_back(reg_addr);
         ntrig++;
      end
      if (ack != 2'b00) begin
         ack_cyc = cyc; ack_port = ack; ack_err_s = ack_err; ack_rdata = rdata;
         ack_log.push_back(ack);
         nack++;
         if (ack[0] && !hold[0]) req[0] = 1'b0;
         if (ack[1] && !hold[1]) req[1] = 1'b0;
      end
      write_done = 1'b0;
      read_done  = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            if (cd_we) write_done = 1'b1;
            else begin read_done = 1'b1; read_byte = mem[cd_addr]; end
            done_cyc = cyc;
         end
      end
      if ((write_trigger || read_trigger) && !mute) begin
         cd = 20; cd_we = write_trigger; cd_addr = reg_addr;
         if (write_trigger) mem[reg_addr] = write_byte;
      end
      if (late_wdone) begin write_done = 1'b1; late_wdone = 0; end
   endtask

   task automatic wait_trig(input int budget, input string name);
      int start = ntrig;
      int k = 0;
      while (ntrig == start && k < budget) begin step(); k++; end
      if (ntrig == start) begin
         checks++; failures++;
         $display("FAIL %s: no trigger within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_ack(input int budget, input string name);
      int start = nack;
      int k = 0;
      while (nack == start && k < budget) begin step(); k++; end
      if (nack == start) begin
         checks++; failures++;
         $display("FAIL %s: no ack within %0d cycles", name, budget);
      end
   endtask

   initial begin
      int k, n0, a0, req_cyc;
      logic [7:0] prev_rdata;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h40);
      rst = 1'b1; req = 2'b00; req_we = 2'b00;
      req_addr0 = 8'h00; req_addr1 = 8'h00; req_wdata0 = 8'h00; req_wdata1 = 8'h00;
      write_done = 1'b0; read_done = 1'b0; read_byte = 8'h00;
      hold = 2'b00; mute = 0; late_wdone = 0;
      repeat (3) step();
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_ack", 32'(ack), 32'h0);
      check("reset_rdata", 32'(rdata), 32'h0);
      check("reset_reg_addr", 32'(reg_addr), 32'h0);
      check("reset_equi_addr", 32'(equi_addr), 32'h50);
      rst = 1'b0;
      step();

      // 1: port 0 write
      n0 = ntrig;
      req_we[0] = 1'b1; req_addr0 = 8'd32; req_wdata0 = 8'h69; req[0] = 1'b1; req_cyc = cyc;
      wait_trig(10, "t1_trigger");
      check("t1_trig_latency", 32'(trig_cyc - req_cyc), 32'd1);
      check("t1_trig_addr", 32'(trig_addr), 32'd32);
      check("t1_trig_wbyte", 32'(trig_wbyte), 32'h69);
      check("t1_trig_is_write", 32'(trig_we), 32'd1);
      wait_ack(300, "t1_ack");
      check("t1_ack_port", 32'(ack_port), 32'b01);
      check("t1_ack_err", 32'(ack_err_s), 32'd0);
      check("t1_ack_after_done", 32'(ack_cyc - done_cyc), 32'd1);
      k = 0;
      while (busy && k < 1000) begin step(); k++; end
      check("t1_busy_cycles_from_ack", 32'(cyc - ack_cyc), 32'd500);
      check("t1_single_trigger", 32'(ntrig - n0), 32'd1);

      // 2: port 1 read back
      req_we[1] = 1'b0; req_addr1 = 8'd32; req[1] = 1'b1;
      wait_trig(10, "t2_trigger");
      check("t2_trig_is_read", 32'(trig_we), 32'd0);
      wait_ack(300, "t2_ack");
      check("t2_ack_port", 32'(ack_port), 32'b10);
      check("t2_rdata", 32'(ack_rdata), 32'h69);
      check("t2_ack_after_done", 32'(ack_cyc - done_cyc), 32'd1);
      repeat (3) step();

      // 3: both ports hold reads, strict alternation from reset priority
      rst = 1'b1; step(); step(); rst = 1'b0;
      trig_log.delete(); ack_log.delete();
      req_we = 2'b00; req_addr0 = 8'd1; req_addr1 = 8'd2;
      hold = 2'b11; req = 2'b11;
      a0 = nack; k = 0;
      while (nack < a0 + 4 && k < 600) begin step(); k++; end
      req = 2'b00; hold = 2'b00;
      repeat (5) step();
      check("t3_trig_count", 32'(trig_log.size()), 32'd4);
      check("t3_ack_count", 32'(ack_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < trig_log.size() && i < ack_log.size(); i++) begin
         check($sformatf("t3_trig_addr_%0d", i), 32'(trig_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("t3_ack_port_%0d", i), 32'(ack_log[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
      end
      check("t3_last_rdata", 32'(rdata), 32'h42);

      // 4: engine never answers
      prev_rdata = rdata;
      mute = 1;
      req_we[0] = 1'b0; req_addr0 = 8'd5; req[0] = 1'b1;
      wait_trig(10, "t4_trigger");
      wait_ack(400, "t4_ack");
      check("t4_ack_err", 32'(ack_err_s), 32'd1);
      check("t4_timeout_latency", 32'(ack_cyc - trig_cyc), 32'd201);
      check("t4_rdata_kept", 32'(ack_rdata), 32'h42);
      check("t4_rdata_prev", 32'(rdata), 32'(prev_rdata));
      mute = 0;
      req_we[1] = 1'b0; req_addr1 = 8'd7; req[1] = 1'b1;
      wait_trig(700, "t4_next_trigger");
      check("t4_recover_gap", 32'(trig_cyc - ack_cyc), 32'd501);
      wait_ack(100, "t4_next_ack");
      check("t4_next_rdata", 32'(ack_rdata), 32'h47);
      step();

      // 5: write then immediate read from the other port
      req_we[0] = 1'b1; req_addr0 = 8'd9; req_wdata0 = 8'h3C; req[0] = 1'b1;
      wait_trig(10, "t5_write_trigger");
      req_we[1] = 1'b0; req_addr1 = 8'd9; req[1] = 1'b1;
      wait_ack(100, "t5_write_ack");
      wait_trig(700, "t5_read_trigger");
      check("t5_read_after_recovery", 32'((trig_cyc - done_cyc) >= 500), 32'd1);
      check("t5_trig_is_read", 32'(trig_we), 32'd0);
      wait_ack(100, "t5_read_ack");
      check("t5_rdata", 32'(ack_rdata), 32'h3C);
      step();

      // 6: reset during WAIT_DONE, then a stray write_done
      mute = 1;
      req_we[0] = 1'b1; req_addr0 = 8'd3; req_wdata0 = 8'h11; req[0] = 1'b1;
      wait_trig(10, "t6_trigger");
      repeat (10) step();
      rst = 1'b1; req = 2'b00;
      step(); step();
      rst = 1'b0;
      a0 = nack;
      late_wdone = 1;
      repeat (30) step();
      check("t6_no_ack", 32'(nack - a0), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_reg_addr", 32'(reg_addr), 32'd0);
      check("t6_write_byte", 32'(write_byte), 32'd0);
      check("t6_rdata", 32'(rdata), 32'd0);
      mute = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eeprom_access_arbiter.md
Name: eeprom_access_arbiter

Overview:
Shares one i2c_ctrler (single-byte EEPROM write/read engine) between two independent requesters (port 0, port 1), e.g. key-driven UI logic and a periodic logger. Round-robin arbitration, one transaction at a time. Latches request fields and issues single-cycle write_trigger/read_trigger pulses. Enforces the AT24C02 internal write-cycle time after every write, with a watchdog on the engine's done pulses. Sits between the requesters and i2c_ctrler inside eeprom top-levels.

Parameters:
SYS_CLK_FREQ  50000000  system clock in Hz
WR_RECOVER_US  5000  post-write idle time in µs (AT24C02 tWR)
TIMEOUT_US  2000  max wait for write_done/read_done before aborting
EQUI_ADDR  7'b1010_000  fixed 7-bit I2C device address driven to the engine

Ports:
sclk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  2  per-port request level; held high until that port's ack
req_we  in  2  per-port: 1 = write, 0 = read
req_addr0, req_addr1  in  8  per-port register address
req_wdata0, req_wdata1  in  8  per-port write data
ack  out  2  per-port one-cycle completion pulse
ack_err  out  1  valid with ack: 1 = timeout abort
rdata  out  8  read result, valid with ack on a read, held until the next read completes
busy  out  1  high whenever state != IDLE
equi_addr  out  7  to i2c_ctrler, constant EQUI_ADDR
reg_addr  out  8  to i2c_ctrler, latched address
write_byte  out  8  to i2c_ctrler, latched data
write_trigger  out  1  to i2c_ctrler, one-cycle pulse
read_trigger  out  1  to i2c_ctrler, one-cycle pulse
write_done  in  1  from i2c_ctrler, one-cycle pulse
read_done  in  1  from i2c_ctrler, one-cycle pulse
read_byte  in  8  from i2c_ctrler, valid on read_done

Behaviour:
- Reset (sync, active-high): state IDLE, ack=0, ack_err=0, rdata=0, busy=0, reg_addr=0, write_byte=0, triggers=0, last_grant=1 (port 0 has priority first), counters=0.
- States: IDLE, ISSUE, WAIT_DONE, RECOVER.
- IDLE: if any req bit is set, grant round-robin: the port other than last_grant wins if requesting, else the requesting port. Latch we/addr/wdata of the winner into reg_addr/write_byte; set last_grant; go ISSUE next cycle.
- ISSUE: exactly one cycle; assert write_trigger (we=1) or read_trigger (we=0); clear watchdog; go WAIT_DONE.
- WAIT_DONE: count cycles. The matching done pulse (write_done for a write, read_done for a read) ends the wait; the non-matching done is ignored.
  - Read done: capture read_byte into rdata; pulse ack[grant] with ack_err=0; go IDLE.
  - Write done: pulse ack[grant] with ack_err=0; load the recovery counter; go RECOVER.
  - Timeout at TIMEOUT_US*SYS_CLK_FREQ/1e6 cycles: pulse ack[grant] with ack_err=1; rdata unchanged; go RECOVER (engine state unknown, so back off conservatively).
- RECOVER: count WR_RECOVER_US*SYS_CLK_FREQ/1e6 cycles, ignoring all req; then go IDLE.
- Latency: grant-to-trigger = 1 cycle after the req sample. A back-to-back request is re-arbitrated in the cycle after returning to IDLE.
- Requests are levels. A requester must drop req within 1 cycle of ack; a req still high in IDLE after its ack is a new request. Request fields are sampled only at grant; later changes have no effect.
- Simultaneous req from both ports: alternate strictly, so neither port waits more than one transaction.
- A done pulse arriving in IDLE or RECOVER is ignored.
- rst mid-transaction: abort immediately, no ack. An in-flight I2C transfer is the engine's responsibility (its own reset).
- Counter widths: $clog2 of the larger cycle count, +1.

Decomposition:
- Package eeprom_arb_pkg: state encoding (2-bit enum), cycle-count constants derived from the parameters, port index constants.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant with last_grant register). The counters stay inline.

Test Plan:
1. Port 0 writes addr 32 data 0x69 with a stubbed engine (write_done 100 cycles after trigger) -> one write_trigger with reg_addr=32, write_byte=0x69; ack[0] 1 cycle after write_done with ack_err=0; busy high through the 250000-cycle recovery.
2. Port 1 reads addr 32, stub returns 0x69 on read_done -> read_trigger pulse only; rdata=0x69 and ack[1] in the cycle after read_done.
3. Both ports hold reads to addr 1 and 2 continuously for 4 transactions -> triggers alternate 0,1,0,1 (reset priority port 0); each ack goes to the correct port.
4. Stub never asserts done -> after exactly 100000 cycles ack pulses with ack_err=1; rdata unchanged; recovery follows before the next grant.
5. Port 0 write immediately followed by a port 1 read request -> read_trigger no earlier than 250000 cycles after write_done.
6. Assert rst during WAIT_DONE, then deliver a late write_done -> all outputs at reset values; no ack; the late done is ignored in IDLE.
